// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, taken-branch,
// multi-cycle EX and data-memory-wait requests into per-register enables, plus perf counters.
//
// state | meaning
// RUN   | normal flow, requests accepted
// LDU   | single load-use bubble cycle, requests masked
// MC    | multi-cycle EX op in progress, pipe held
module pipe_stall_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_use_i,
  input  logic             br_taken_i,
  input  logic             mc_start_i,
  input  logic             dmem_wait_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int CW = $clog2(MC_LAT);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    LDU = 2'd1,
    MC  = 2'd2
  } state_t;

  state_t          state_q, state_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            flush_inc;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    exmem_write_o = 1'b1;
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    flush_inc     = 1'b0;

    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      exmem_write_o = 1'b0;
    end else if (dmem_wait_i) begin
      // global freeze: state and cnt hold, other requests dropped
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_write_o  = 1'b0;
      exmem_write_o = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mc_start_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
            cnt_nxt       = CW'(MC_LAT - 1);
            state_nxt     = MC;
          end else if (br_taken_i) begin
            // load-use on a wrong-path instruction is irrelevant once it is flushed
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            flush_inc     = 1'b1;
          end else if (ld_use_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            state_nxt     = LDU;
          end
        end
        LDU: begin
          state_nxt = RUN;
        end
        MC: begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_write_o  = 1'b0;
          exmem_write_o = 1'b0;
          cnt_nxt       = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (!pc_write_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc)   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (MC_LAT=4): reset, load-use, multi-cycle,
// branch flush, memory-wait freeze and mid-sequence reset.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst, ld_use, br_taken, mc_start, dmem_wait;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_stall_ctrl #(.MC_LAT(4), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ld_use_i     (ld_use),
    .br_taken_i   (br_taken),
    .mc_start_i   (mc_start),
    .dmem_wait_i  (dmem_wait),
    .pc_write_o   (pc_write),
    .ifid_write_o (ifid_write),
    .ifid_flush_o (ifid_flush),
    .idex_write_o (idex_write),
    .idex_bubble_o(idex_bubble),
    .exmem_write_o(exmem_write),
    .state_o      (state),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  always #5 clk = ~clk;

  // advance one cycle; inputs change 1 time unit after the edge, outputs sampled 1 later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_use = 1'b0; br_taken = 1'b0; mc_start = 1'b0; dmem_wait = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble} !== 6'b000011) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b want 000011", i,
                 {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble});
      end
      step();
    end
    rst = 1'b0;
    exp_stall = 0; exp_flush = 0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++;
      $display("FAIL reset_state: state=%0d stall=%0d flush=%0d want 0 0 0", state, stall_cnt, flush_cnt);
    end
    checks++;
    if ({pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble} !== 6'b111100) begin
      errors++;
      $display("FAIL reset_release_defaults: got %b want 111100",
               {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble});
    end
  endtask

  task automatic test_ld_use();
    ld_use = 1'b1;
    #1;
    checks++;
    if ({pc_write, ifid_write, idex_bubble, exmem_write, state} !== 6'b001100) begin
      errors++;
      $display("FAIL ldu_first: pc/ifid/bub/exm/state got %b want 001100",
               {pc_write, ifid_write, idex_bubble, exmem_write, state});
    end
    exp_stall++;
    step();
    checks++;
    if (state !== 2'd1 || pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL ldu_second: state=%0d pc_write=%b bubble=%b want 1 1 0", state, pc_write, idex_bubble);
    end
    step();
    ld_use = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== CNT_W'(exp_stall)) begin
      errors++;
      $display("FAIL ldu_done: state=%0d stall=%0d want 0 %0d", state, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_ldu_masks_branch();
    ld_use = 1'b1;
    exp_stall++;
    step();
    ld_use = 1'b0; br_taken = 1'b1;
    #1;
    checks++;
    if (state !== 2'd1 || ifid_flush !== 1'b0 || idex_bubble !== 1'b0 || pc_write !== 1'b1) begin
      errors++;
      $display("FAIL ldu_mask_br: state=%0d flush=%b bubble=%b pc=%b want 1 0 0 1",
               state, ifid_flush, idex_bubble, pc_write);
    end
    step();
    br_taken = 1'b0;
    #1;
    checks++;
    if (flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
      errors++;
      $display("FAIL ldu_mask_cnt: flush=%0d stall=%0d want %0d %0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_mc();
    mc_start = 1'b1;
    #1;
    checks++;
    if (pc_write !== 1'b0 || exmem_write !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL mc_start: pc=%b exmem=%b state=%0d want 0 0 0", pc_write, exmem_write, state);
    end
    step();
    mc_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== 2'd2 || pc_write !== 1'b0 || exmem_write !== 1'b0) begin
        errors++;
        $display("FAIL mc_hold %0d: state=%0d pc=%b exmem=%b want 2 0 0", i, state, pc_write, exmem_write);
      end
      step();
    end
    exp_stall += 4;
    checks++;
    if (state !== 2'd0 || pc_write !== 1'b1 || stall_cnt !== CNT_W'(exp_stall)) begin
      errors++;
      $display("FAIL mc_done: state=%0d pc=%b stall=%0d want 0 1 %0d", state, pc_write, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_br_ld();
    br_taken = 1'b1; ld_use = 1'b1;
    #1;
    checks++;
    if ({pc_write, ifid_flush, idex_bubble, exmem_write} !== 4'b1111) begin
      errors++;
      $display("FAIL br_ld: pc/flush/bub/exm got %b want 1111", {pc_write, ifid_flush, idex_bubble, exmem_write});
    end
    exp_flush++;
    step();
    br_taken = 1'b0; ld_use = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || flush_cnt !== CNT_W'(exp_flush) || stall_cnt !== CNT_W'(exp_stall)) begin
      errors++;
      $display("FAIL br_ld_cnt: state=%0d flush=%0d stall=%0d want 0 %0d %0d",
               state, flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_dmem_run();
    dmem_wait = 1'b1; mc_start = 1'b1; br_taken = 1'b1;
    #1;
    checks++;
    if ({pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble} !== 6'b000000) begin
      errors++;
      $display("FAIL dmem_run_out: got %b want 000000",
               {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble});
    end
    exp_stall++;
    step();
    dmem_wait = 1'b0; mc_start = 1'b0; br_taken = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== CNT_W'(exp_stall) || flush_cnt !== CNT_W'(exp_flush)) begin
      errors++;
      $display("FAIL dmem_run_state: state=%0d stall=%0d flush=%0d want 0 %0d %0d",
               state, stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_dmem_mc();
    int stalls;
    stalls = 0;
    mc_start = 1'b1;
    #1;
    if (pc_write === 1'b0) stalls++;
    step();
    mc_start = 1'b0;
    if (pc_write === 1'b0) stalls++;
    step();
    dmem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state !== 2'd2 || exmem_write !== 1'b0 || pc_write !== 1'b0 || idex_bubble !== 1'b0) begin
        errors++;
        $display("FAIL dmem_mc_freeze %0d: state=%0d exmem=%b pc=%b bub=%b want 2 0 0 0",
                 i, state, exmem_write, pc_write, idex_bubble);
      end
      if (pc_write === 1'b0) stalls++;
      step();
    end
    dmem_wait = 1'b0;
    for (int i = 0; i < 10 && state !== 2'd0; i++) begin
      #1;
      if (exmem_write !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL dmem_mc_exmem: exmem=%b want 0", exmem_write);
      end
      if (pc_write === 1'b0) stalls++;
      step();
    end
    exp_stall += 7;
    checks++;
    if (stalls !== 7 || state !== 2'd0) begin
      errors++;
      $display("FAIL dmem_mc_len: stall cycles=%0d state=%0d want 7 0", stalls, state);
    end
    checks++;
    if (stall_cnt !== CNT_W'(exp_stall)) begin
      errors++;
      $display("FAIL dmem_mc_cnt: stall=%0d want %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_reset_mid_mc();
    int stalls;
    mc_start = 1'b1;
    step();
    mc_start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (pc_write !== 1'b0 || ifid_flush !== 1'b1 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL rst_mc_out: pc=%b flush=%b bub=%b want 0 1 1", pc_write, ifid_flush, idex_bubble);
    end
    step();
    rst = 1'b0;
    exp_stall = 0; exp_flush = 0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      errors++;
      $display("FAIL rst_mc_state: state=%0d stall=%0d flush=%0d want 0 0 0", state, stall_cnt, flush_cnt);
    end
    checks++;
    if ({pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble} !== 6'b111100) begin
      errors++;
      $display("FAIL rst_mc_defaults: got %b want 111100",
               {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble});
    end
    // a fresh multi-cycle op must still stall exactly MC_LAT cycles
    stalls = 0;
    mc_start = 1'b1;
    #1;
    if (pc_write === 1'b0) stalls++;
    step();
    mc_start = 1'b0;
    for (int i = 0; i < 10 && state !== 2'd0; i++) begin
      if (pc_write === 1'b0) stalls++;
      step();
    end
    checks++;
    if (stalls !== 4 || state !== 2'd0) begin
      errors++;
      $display("FAIL rst_mc_restart: stall cycles=%0d state=%0d want 4 0", stalls, state);
    end
  endtask

  initial begin
    test_reset();
    test_ld_use();
    test_ldu_masks_branch();
    test_mc();
    test_br_ld();
    test_dmem_run();
    test_dmem_mc();
    test_reset_mid_mc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
